// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: multi-cycle MULT/MULTU (and DIV/DIVU when
// MDU_DIV_EN is defined) with HI/LO registers and a D-stage stall request.
module mdu_ctrl #(
   parameter int unsigned MUL_CYC = 5,
   parameter int unsigned DIV_CYC = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        md_use_d,
   output logic        stall_md,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned CNT_W = 4;

`ifdef MDU_DIV_EN
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;
   localparam bit DIV_EN = 1'b1;
`else
   typedef enum logic [1:0] {S_IDLE, S_MUL} state_e;
   localparam bit DIV_EN = 1'b0;
`endif

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        a_q, a_d, b_q, b_d;
   logic               sgn_q, sgn_d;
   logic [31:0]        hi_q, hi_d, lo_q, lo_d;
   logic               busy_q, busy_d, done_q, done_d;
   logic               is_mul_op, is_div_op;
   logic [63:0]        prod;

   assign is_mul_op = (md_op[2:1] == 2'b00);
   assign is_div_op = DIV_EN && (md_op[2:1] == 2'b01);

   // Stall must act in the same cycle the D-stage instruction is decoded.
   assign stall_md = md_use_d & (busy_q | (start & (is_mul_op | is_div_op)));

   // Sign-extend only for signed ops so one 64-bit multiplier serves both.
   assign prod = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};

`ifdef MDU_DIV_EN
   logic        neg_a, neg_b;
   logic [31:0] ua, ub, uq, ur, quo, rem;

   // Magnitude divide, then restore signs: quotient truncates toward zero,
   // remainder follows the dividend.
   always_comb begin
      neg_a = sgn_q & a_q[31];
      neg_b = sgn_q & b_q[31];
      ua    = neg_a ? -a_q : a_q;
      ub    = neg_b ? -b_q : b_q;
      uq    = (ub == 32'd0) ? 32'd0 : ua / ub;
      ur    = (ub == 32'd0) ? 32'd0 : ua % ub;
      quo   = (neg_a ^ neg_b) ? -uq : uq;
      rem   = neg_a ? -ur : ur;
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (is_mul_op || is_div_op) begin
                  a_d     = src_a;
                  b_d     = src_b;
                  sgn_d   = ~md_op[0];
                  busy_d  = 1'b1;
                  cnt_d   = is_div_op ? CNT_W'(DIV_CYC - 1) : CNT_W'(MUL_CYC - 1);
                  state_d = S_MUL;
`ifdef MDU_DIV_EN
                  if (is_div_op) state_d = S_DIV;
`endif
               end else if (md_op == 3'd4) begin
                  hi_d = src_a;
               end else if (md_op == 3'd5) begin
                  lo_d = src_a;
               end
            end
         end
         default: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
`ifdef MDU_DIV_EN
               if (state_q == S_DIV) begin
                  if (b_q != 32'd0) begin
                     hi_d = rem;
                     lo_d = quo;
                  end
               end else
`endif
               begin
                  hi_d = prod[63:32];
                  lo_d = prod[31:0];
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MUL_CYC, default 5: busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYC, default 10: busy cycles for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  E-stage MDU instruction valid this cycle.
REQ-006 md_op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
REQ-007 src_a  input  32  forwarded rs value (E stage).
REQ-008 src_b  input  32  forwarded rt value (E stage).
REQ-009 md_use_d  input  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
REQ-010 stall_md  output  1  stall request to hazard unit, OR-ed with existing Stall.
REQ-011 busy  output  1  operation in progress.
REQ-012 done  output  1  one-cycle pulse on HI/LO update by MUL/DIV.
REQ-013 hi  output  32  HI register.
REQ-014 lo  output  32  LO register.

Function
REQ-015 FSM states IDLE, MUL, DIV; 4-bit cycle counter cnt.
REQ-016 IDLE, start=1, md_op 0/1 at edge T: operands latched, state MUL, cnt=MUL_CYC-1, busy=1 from T onward.
REQ-017 IDLE, start=1, md_op 2/3 at edge T: operands latched, state DIV, cnt=DIV_CYC-1, busy=1 from T onward.
REQ-018 MUL/DIV: cnt decrements each edge; edge where cnt==0: hi/lo written, state IDLE, busy=0, done=1 for exactly one cycle.
REQ-019 busy high exactly MUL_CYC (resp. DIV_CYC) cycles per operation.
REQ-020 MULT: signed 32x32->64; MULTU: unsigned; hi=product[63:32], lo=product[31:0].
REQ-021 DIV/DIVU: lo=quotient, hi=remainder; signed truncates toward zero, remainder takes sign of dividend.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
REQ-023 Divisor 0: full DIV_CYC busy sequence, done pulses, hi/lo unchanged.
REQ-024 IDLE, start=1, md_op 4: hi=src_a at edge; md_op 5: lo=src_a; no busy, no done.
REQ-025 md_op 6/7 or start=0: no state change.
REQ-026 start=1 while busy=1: ignored entirely (hi/lo, cnt, state unchanged).
REQ-027 stall_md = md_use_d & (busy | (start & md_op<=3)), combinational, no registered delay.
REQ-028 Result computed from latched operands; src_a/src_b changes during busy have no effect.
REQ-029 done and start coinciding at edge (state IDLE next): new start accepted the following cycle only.

Reset
REQ-030 rst_n=0 asynchronously forces state IDLE, cnt=0, busy=0, done=0, stall_md=md_use_d&start&(md_op<=3), hi=0, lo=0.
REQ-031 Reset mid-operation aborts it; no done pulse, hi/lo=0 after release.
REQ-032 First edge after rst_n rises behaves as IDLE.

Configuration
REQ-033 Macro MDU_DIV_EN defined: DIV/DIVU per REQ-017, REQ-021..023.
REQ-034 MDU_DIV_EN undefined: md_op 2/3 treated as no-op (no busy, no stall term, hi/lo unchanged); DIV state and divider logic absent.

Verification
REQ-035 MULT src_a=0xFFFFFFFE (-2), src_b=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one cycle.
REQ-036 MULTU src_a=0xFFFFFFFF, src_b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
REQ-037 DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi/lo unchanged, done pulses.
REQ-038 MULT started, md_use_d=1 during busy -> stall_md=1 every busy cycle and 0 the cycle after done; second start mid-busy ignored.
REQ-039 MTHI src_a=0x12345678 -> hi=0x12345678 next edge, busy stays 0; MTLO during busy -> lo unchanged.
REQ-040 rst_n low in 3rd cycle of DIV -> busy=0, hi=lo=0 immediately, no done; MDU_DIV_EN undefined build: DIV start -> busy stays 0.
